// File: rtl/link_pkg.sv
// Shared link parameters and types for the board packet transmitter and its partner receiver.
package link_pkg;

    localparam int LINK_PKT_LEN   = 208;
    localparam int LINK_DIVISOR   = 6771;
    localparam int LINK_GAP_COUNT = 130_000;
    localparam int BYTES_PER_PKT  = LINK_PKT_LEN / 8;

    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } tx_state_t;

endpackage

// File: rtl/board_pkt_tx_baud_tick_gen.sv
// Free-running period counter with synchronous clear; tick is high on the last count of each period.
module baud_tick_gen
    import link_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT)
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clr_in,
    output logic tick_out
);

    localparam logic [W-1:0] TERM = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    assign tick_out = (r_count == TERM);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clr_in) begin
            r_count <= '0;
        end else if (tick_out) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/board_pkt_tx.sv
// UART-style packet serializer: 8N1 bytes back-to-back, LSB first, then a mandatory idle-high gap
// so the partner receiver can frame packets by line-idle time.
//
// state | meaning
// IDLE  | line high, waiting for trigger_in
// START | start bit (0)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1)
// GAP   | line held high for GAP_COUNT cycles
module board_pkt_tx
    import link_pkg::*;
#(
    parameter int CLK_HZ    = 65_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DIVISOR   = LINK_DIVISOR,
    parameter int PKT_LEN   = LINK_PKT_LEN,
    parameter int GAP_COUNT = LINK_GAP_COUNT
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               trigger_in,
    input  logic [PKT_LEN-1:0] val_in,
    output logic               data_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam int NBYTES = PKT_LEN / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int GW     = $clog2(GAP_COUNT + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

    if ((PKT_LEN % 8) != 0 || PKT_LEN < 8) begin : g_bad_pkt_len
        $error("board_pkt_tx: PKT_LEN must be a non-zero multiple of 8");
    end
    if (DIVISOR < 2 || GAP_COUNT < 1) begin : g_bad_timing
        $error("board_pkt_tx: DIVISOR must be >= 2 and GAP_COUNT >= 1");
    end
    if ((CLK_HZ / BAUD_RATE) != DIVISOR) begin : g_divisor_note
        $warning("board_pkt_tx: DIVISOR differs from CLK_HZ/BAUD_RATE");
    end

    tx_state_t          r_state;
    logic [PKT_LEN-1:0] r_shift;
    logic [2:0]         r_bit_cnt;
    logic [BW-1:0]      r_byte_idx;
    logic               r_data;
    logic               r_busy;
    logic               r_done;

    logic w_baud_tick;
    logic w_gap_tick;
    logic w_baud_clr;
    logic w_gap_clr;

    assign w_baud_clr = (r_state == IDLE) || (r_state == GAP);
    assign w_gap_clr  = (r_state != GAP);

    baud_tick_gen #(
        .LIMIT (DIVISOR),
        .W     ($clog2(DIVISOR))
    ) u_baud (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr_in   (w_baud_clr),
        .tick_out (w_baud_tick)
    );

    // Same counter reused as the inter-packet gap timer.
    baud_tick_gen #(
        .LIMIT (GAP_COUNT),
        .W     (GW)
    ) u_gap (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr_in   (w_gap_clr),
        .tick_out (w_gap_tick)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_data     <= LINE_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (trigger_in) begin
                        r_shift    <= val_in;
                        r_byte_idx <= '0;
                        r_bit_cnt  <= '0;
                        r_data     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_baud_tick) begin
                        r_data    <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_baud_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == 3'd7) begin
                            r_data  <= LINE_IDLE;
                            r_state <= STOP;
                        end else begin
                            r_data    <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_baud_tick) begin
                        if (r_byte_idx == LAST_BYTE) begin
                            r_done  <= 1'b1;
                            r_state <= GAP;
                        end else begin
                            r_byte_idx <= r_byte_idx + BW'(1);
                            r_data     <= 1'b0;
                            r_state    <= START;
                        end
                    end
                end
                GAP: begin
                    if (w_gap_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_data  <= LINE_IDLE;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data;
    assign busy_out = r_busy;
    assign done_out = r_done;

endmodule

// File: tb/tb_board_pkt_tx.sv
// Directed and randomized bench for board_pkt_tx with a waveform-level reference of the line.
module tb_board_pkt_tx;

    localparam int DIV   = 4;
    localparam int PLEN  = 16;
    localparam int GAPC  = 10;
    localparam int NB    = PLEN / 8;
    localparam int LINE_CYC = NB * 10 * DIV;
    localparam int BUSY_CYC = LINE_CYC + GAPC;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            trigger;
    logic [PLEN-1:0] val;
    logic            data_o;
    logic            busy_o;
    logic            done_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    board_pkt_tx #(
        .CLK_HZ    (DIV * 9600),
        .BAUD_RATE (9600),
        .DIVISOR   (DIV),
        .PKT_LEN   (PLEN),
        .GAP_COUNT (GAPC)
    ) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .trigger_in (trigger),
        .val_in     (val),
        .data_out   (data_o),
        .busy_out   (busy_o),
        .done_out   (done_o)
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, idx, obs, exp);
    endtask

    // Expected line level i cycles after the accepting edge: 10 line bits per byte, DIV cycles each.
    function automatic logic exp_line(input logic [PLEN-1:0] pkt, input int i);
        int bit_pos;
        int byte_no;
        int slot;
        if (i >= LINE_CYC) return 1'b1;
        bit_pos = i / DIV;
        byte_no = bit_pos / 10;
        slot    = bit_pos % 10;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return pkt[byte_no*8 + slot - 1];
    endfunction

    // Called with trigger already high for the accepting edge; walks the whole busy window.
    task automatic run_packet(input logic [PLEN-1:0] pkt, input bit disturb, input bit chain,
                              input logic [PLEN-1:0] nxt);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i <= BUSY_CYC; i++) begin
            if (i > 0) @(negedge clk);
            chk("data_out", i, 32'(data_o), 32'(exp_line(pkt, i)));
            chk("busy_out", i, 32'(busy_o), 32'(i < BUSY_CYC));
            chk("done_out", i, 32'(done_o), 32'(i == LINE_CYC));
            trigger = 1'b0;
            if (disturb && (i == 10 || i == LINE_CYC + 5)) begin
                trigger = 1'b1;
                val     = PLEN'($urandom);
            end
            if (chain && (i == BUSY_CYC - 1 || i == BUSY_CYC)) begin
                trigger = 1'b1;
                val     = nxt;
            end
        end
    endtask

    task automatic start_packet(input logic [PLEN-1:0] pkt, input bit disturb);
        @(negedge clk);
        trigger = 1'b1;
        val     = pkt;
        run_packet(pkt, disturb, 1'b0, '0);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_data"}, i, 32'(data_o), 32'(1));
            chk({tag, "_busy"}, i, 32'(busy_o), 32'(0));
            chk({tag, "_done"}, i, 32'(done_o), 32'(0));
        end
    endtask

    initial begin
        logic [PLEN-1:0] pkt;

        rst_n   = 1'b0;
        trigger = 1'b0;
        val     = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", 0, 32'(data_o), 32'(1));
        chk("rst_busy", 0, 32'(busy_o), 32'(0));
        chk("rst_done", 0, 32'(done_o), 32'(0));
        rst_n = 1'b1;
        idle_check("idle", 3);

        // Reset while byte 0 data bits are on the line; packet must be abandoned.
        @(negedge clk);
        trigger = 1'b1;
        val     = PLEN'($urandom);
        @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", 10, 32'(busy_o), 32'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_data", 0, 32'(data_o), 32'(1));
        chk("midrst_busy", 0, 32'(busy_o), 32'(0));
        chk("midrst_done", 0, 32'(done_o), 32'(0));
        rst_n = 1'b1;
        idle_check("abandon", 100);

        pkt = PLEN'($urandom);
        start_packet(pkt, 1'b0);

        start_packet(16'hA53C, 1'b0);

        // Triggers during DATA and GAP with val_in churn must not disturb or queue.
        for (int k = 0; k < 3; k++) begin
            pkt = PLEN'($urandom);
            start_packet(pkt, 1'b1);
            idle_check("noqueue", 15);
        end

        // Trigger on the edge busy falls is ignored; the one a cycle later starts the next packet.
        @(negedge clk);
        trigger = 1'b1;
        val     = 16'h0000;
        run_packet(16'h0000, 1'b0, 1'b1, 16'hFFFF);
        run_packet(16'hFFFF, 1'b0, 1'b1, 16'h5A96);
        run_packet(16'h5A96, 1'b0, 1'b0, '0);
        idle_check("tail", 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
